// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's req/gnt/rvalid port: word array with byte
// enables, a programmable grant wait and a fixed-latency in-order response pipe.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int GNT_WAIT   = 0,
  parameter int RVALID_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_DEPTH * 4);
  localparam logic [3:0] WAIT_N = 4'(GNT_WAIT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    xfer_s;
  logic                    oor_s;
  logic [AW-1:0]           idx_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic [DATA_WIDTH-1:0]   resp_data_s;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic [RVALID_LAT-1:0]   vld_q;
  logic [RVALID_LAT-1:0]   err_q;
  logic [DATA_WIDTH-1:0]   dat_q [RVALID_LAT];

  // Grant decode: immediate when no wait is configured, else after N held cycles
  always_comb begin
    data_gnt_o = 1'b0;
    if (GNT_WAIT == 0) begin
      data_gnt_o = data_req_i;
    end else begin
      data_gnt_o = data_req_i && (state_q == S_WAIT) && (cnt_q == WAIT_N);
    end
  end

  assign xfer_s      = data_req_i & data_gnt_o;
  assign oor_s       = (data_addr_i >= ADDR_LIMIT);
  assign idx_s       = data_addr_i[AW+1:2];
  assign rd_word_s   = mem_q[idx_s];
  assign resp_data_s = (data_we_i || oor_s) ? '0 : rd_word_s;

  // Grant wait FSM; dropping req while waiting abandons the count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else if (GNT_WAIT == 0) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (data_req_i) begin
            state_q <= S_WAIT;
            cnt_q   <= 4'd1;
          end
        end
        S_WAIT: begin
          if (!data_req_i || (cnt_q == WAIT_N)) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Storage array, byte-lane writes; deliberately not reset
  always_ff @(posedge clk_i) begin
    if (xfer_s && data_we_i && !oor_s) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) mem_q[idx_s][8*i +: 8] <= data_wdata_i[8*i +: 8];
      end
    end
  end

  // Response pipe: each stage only loads payload when its input is valid, so the
  // last stage holds rdata/err between responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RVALID_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= xfer_s;
      if (xfer_s) begin
        err_q[0] <= oor_s;
        dat_q[0] <= resp_data_s;
      end
      for (int i = 1; i < RVALID_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          err_q[i] <= err_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign data_rvalid_o = vld_q[RVALID_LAT-1];
  assign data_err_o    = err_q[RVALID_LAT-1];
  assign data_rdata_o  = dat_q[RVALID_LAT-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three configurations checked every cycle against a
// cycle-scheduled response model, plus literal expectations for the directed cases.
module tb_data_mem_responder;

  function automatic int gw(int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int lt(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be_v);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be_v[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic        clk;
  logic        rst_n;
  logic        req [3];
  logic        we [3];
  logic [3:0]  be [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic [31:0] rdata [3];
  logic        err [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DATA_WIDTH(32), .MEM_DEPTH(1024), .GNT_WAIT(gw(g)), .RVALID_LAT(lt(g))
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .data_req_i(req[g]), .data_gnt_o(gnt[g]),
      .data_addr_i(addr[g]), .data_we_i(we[g]), .data_be_i(be[g]),
      .data_wdata_i(wdata[g]),
      .data_rvalid_o(rvalid[g]), .data_rdata_o(rdata[g]), .data_err_o(err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per-instance memory, a count of consecutive un-granted req cycles, and a
  // cycle-indexed schedule of the responses that must appear
  int          cyc;
  int          h [3];
  logic [31:0] mem_m [3][1024];
  logic        sv_v [3][16];
  logic [31:0] sv_d [3][16];
  logic        sv_e [3][16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        h[k] <= 0;
        for (int s = 0; s < 16; s++) sv_v[k][s] <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 3; k++) begin
        sv_v[k][cyc % 16] <= 1'b0;
        if (req[k] && h[k] == gw(k)) begin
          h[k] <= 0;
          sv_v[k][(cyc + lt(k)) % 16] <= 1'b1;
          sv_e[k][(cyc + lt(k)) % 16] <= (addr[k] >= 32'h0000_1000);
          if (addr[k] >= 32'h0000_1000 || we[k]) begin
            sv_d[k][(cyc + lt(k)) % 16] <= 32'h0000_0000;
          end else begin
            sv_d[k][(cyc + lt(k)) % 16] <= mem_m[k][addr[k][11:2]];
          end
          if (we[k] && addr[k] < 32'h0000_1000)
            mem_m[k][addr[k][11:2]] <= merge(mem_m[k][addr[k][11:2]], wdata[k], be[k]);
        end else if (req[k]) begin
          h[k] <= h[k] + 1;
        end else begin
          h[k] <= 0;
        end
      end
    end
  end

  typedef struct {int k; logic [31:0] d; logic e; int c;} obs_t;
  obs_t        obs [$];
  int          checks;
  int          errors;
  logic        gnt_seen [3];
  logic [31:0] last_d [3];
  logic        last_e [3];

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic ev;
    for (int k = 0; k < 3; k++) begin
      gnt_seen[k] = gnt[k];
      chk("gnt", k, 32'(gnt[k]), 32'(rst_n && req[k] && (h[k] == gw(k))));
      ev = 1'b0;
      if (!rst_n) begin
        last_d[k] = 32'h0000_0000;
        last_e[k] = 1'b0;
      end else if (sv_v[k][cyc % 16]) begin
        ev        = 1'b1;
        last_d[k] = sv_d[k][cyc % 16];
        last_e[k] = sv_e[k][cyc % 16];
      end
      chk("rvalid", k, 32'(rvalid[k]), 32'(ev));
      chk("rdata", k, rdata[k], last_d[k]);
      chk("err", k, 32'(err[k]), 32'(last_e[k]));
      if (rst_n && rvalid[k]) obs.push_back('{k, rdata[k], err[k], cyc});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int k, logic [31:0] a, logic w, logic [3:0] b, logic [31:0] d, output int n);
    logic got;
    req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = gnt_seen[k];
      n = i + 1;
    end
    chk("grant_timeout", k, 32'(got), 32'd1);
  endtask

  task automatic idle(int k);
    req[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic lit(string nm, int k, logic [31:0] d, logic e, int c_exp);
    obs_t o;
    checks++;
    if (obs.size() == 0) begin
      errors++;
      $display("FAIL %s no response seen, expected inst %0d data %h err %0d", nm, k, d, e);
    end else begin
      o = obs.pop_front();
      if (o.k != k || o.d !== d || o.e !== e || (c_exp >= 0 && o.c != c_exp)) begin
        errors++;
        $display("FAIL %s got inst %0d data %h err %0d cyc %0d expected inst %0d data %h err %0d cyc %0d",
                 nm, o.k, o.d, o.e, o.c, k, d, e, c_exp);
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
      gnt_seen[k] = 1'b0; last_d[k] = 32'h0; last_e[k] = 1'b0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
      chk("rst_rdata", k, rdata[k], 32'h0000_0000);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // Write then read, zero wait, latency 1
    obs.delete();
    issue(0, 32'h10, 1'b1, 4'hF, 32'hCAFE_BABE, n);
    chk("nowait_w", 0, 32'(n), 32'd1);
    issue(0, 32'h10, 1'b0, 4'hF, 32'h0, n);
    chk("nowait_r", 0, 32'(n), 32'd1);
    idle(0);
    repeat (3) tick();
    lit("wr_resp", 0, 32'h0000_0000, 1'b0, -1);
    lit("rd_resp", 0, 32'hCAFE_BABE, 1'b0, -1);

    // Byte enables
    issue(0, 32'h20, 1'b1, 4'hF, 32'h1122_3344, n);
    issue(0, 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD, n);
    issue(0, 32'h20, 1'b0, 4'h0, 32'h0, n);
    idle(0);
    repeat (3) tick();
    lit("be_pre", 0, 32'h0, 1'b0, -1);
    lit("be_wr", 0, 32'h0, 1'b0, -1);
    lit("be_rd", 0, 32'h11BB_33DD, 1'b0, -1);

    // Out of range write/read, then check word 0 untouched
    issue(0, 32'h0, 1'b1, 4'hF, 32'h55AA_55AA, n);
    issue(0, 32'h1000, 1'b1, 4'hF, 32'hDEAD_BEEF, n);
    issue(0, 32'h1000, 1'b0, 4'hF, 32'h0, n);
    issue(0, 32'h0, 1'b0, 4'hF, 32'h0, n);
    idle(0);
    repeat (3) tick();
    lit("oor_pre", 0, 32'h0, 1'b0, -1);
    lit("oor_wr", 0, 32'h0, 1'b1, -1);
    lit("oor_rd", 0, 32'h0, 1'b1, -1);
    lit("oor_keep", 0, 32'h55AA_55AA, 1'b0, -1);

    // Latency 3: three back-to-back reads
    issue(2, 32'h0, 1'b1, 4'hF, 32'h1010_1010, n);
    issue(2, 32'h4, 1'b1, 4'hF, 32'h2020_2020, n);
    issue(2, 32'h8, 1'b1, 4'hF, 32'h3030_3030, n);
    idle(2);
    repeat (5) tick();
    obs.delete();
    issue(2, 32'h0, 1'b0, 4'hF, 32'h0, n);
    g0 = cyc;
    issue(2, 32'h4, 1'b0, 4'hF, 32'h0, n);
    issue(2, 32'h8, 1'b0, 4'hF, 32'h0, n);
    idle(2);
    repeat (6) tick();
    lit("pipe0", 2, 32'h1010_1010, 1'b0, g0 + 2);
    lit("pipe1", 2, 32'h2020_2020, 1'b0, g0 + 3);
    lit("pipe2", 2, 32'h3030_3030, 1'b0, g0 + 4);

    // Grant wait of 2: held req, then a dropped req that restarts the wait
    req[1] = 1'b1; addr[1] = 32'h40; we[1] = 1'b1; be[1] = 4'hF; wdata[1] = 32'h0000_0A0A;
    tick(); chk("gw_c0", 1, 32'(gnt_seen[1]), 32'd0);
    tick(); chk("gw_c1", 1, 32'(gnt_seen[1]), 32'd0);
    tick(); chk("gw_c2", 1, 32'(gnt_seen[1]), 32'd1);
    idle(1);
    repeat (2) tick();
    req[1] = 1'b1; we[1] = 1'b1; wdata[1] = 32'h0000_0B0B;
    tick(); chk("gwd_c0", 1, 32'(gnt_seen[1]), 32'd0);
    req[1] = 1'b0;
    tick(); chk("gwd_c1", 1, 32'(gnt_seen[1]), 32'd0);
    req[1] = 1'b1;
    tick(); chk("gwd_c2", 1, 32'(gnt_seen[1]), 32'd0);
    tick(); chk("gwd_c3", 1, 32'(gnt_seen[1]), 32'd0);
    tick(); chk("gwd_c4", 1, 32'(gnt_seen[1]), 32'd1);
    idle(1);
    issue(1, 32'h40, 1'b0, 4'hF, 32'h0, n);
    chk("gw_wait", 1, 32'(n), 32'd3);
    idle(1);
    repeat (4) tick();
    lit("gw_wr0", 1, 32'h0, 1'b0, -1);
    lit("gw_wr1", 1, 32'h0, 1'b0, -1);
    lit("gw_rd", 1, 32'h0000_0B0B, 1'b0, -1);

    // Reset one cycle after a granted read; its response must never appear
    obs.delete();
    issue(1, 32'h40, 1'b0, 4'hF, 32'h0, n);
    idle(1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_now_rvalid", 1, 32'(rvalid[1]), 32'd0);
    chk("rst_now_gnt", 1, 32'(gnt[1]), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_no_resp", 1, 32'(obs.size()), 32'd0);
    issue(1, 32'h40, 1'b0, 4'hF, 32'h0, n);
    idle(1);
    repeat (4) tick();
    lit("post_rst_rd", 1, 32'h0000_0B0B, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
